// File: rtl/serial_frame_transmitter.sv
// serial_frame_transmitter
// Shifts a WORD_WIDTH*FRAME_WORDS frame out on transmission/out_clock/out_data.
// The bit clock is divided down from clk internally. An idle gap follows each
// frame, and busy/done give the handshake.
// Optional build macro: SERIAL_FRAME_PARITY_EN appends one even-parity
// bit after each word. When the macro is undefined, no parity logic exists.
module serial_frame_transmitter #(
  parameter int WORD_WIDTH  = 8,
  parameter int FRAME_WORDS = 8,
  parameter int CLK_DIV     = 4,
  parameter int MSB_FIRST   = 1,
  parameter int IDLE_GAP    = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              send,
  input  logic [WORD_WIDTH*FRAME_WORDS-1:0] data,
  output logic                              busy,
  output logic                              done,
  output logic                              transmission,
  output logic                              out_clock,
  output logic                              out_data
);

  localparam int TOTAL = WORD_WIDTH * FRAME_WORDS;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int BITS_PER_WORD = WORD_WIDTH + 1;
`else
  localparam int BITS_PER_WORD = WORD_WIDTH;
`endif
  localparam int LAST_BIT = BITS_PER_WORD - 1;
  localparam int BCW      = (LAST_BIT > 0) ? $clog2(LAST_BIT + 1) : 1;
  localparam int WCW      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int DCW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_CYC  = IDLE_GAP * 2 * CLK_DIV;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int GCW      = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q;
  logic [TOTAL-1:0] sr_q;
  logic [DCW-1:0]   div_q;
  logic             phase_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [WCW-1:0]   word_cnt_q;
  logic [GCW-1:0]   gap_q;
  logic             busy_q;
  logic             done_q;
  logic             tx_q;
  logic             oclk_q;
  logic             odat_q;

  logic [TOTAL-1:0] sr_shift_d;
  logic             first_bit_d;
  logic             shift_head_d;
  logic             div_tc_d;
  logic             last_bit_d;
  logic             last_word_d;

  // Shift direction, the next bit to send and the terminal-count decodes
  always_comb begin
    sr_shift_d   = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);
    first_bit_d  = (MSB_FIRST != 0) ? data[TOTAL-1] : data[0];
    shift_head_d = (MSB_FIRST != 0) ? sr_shift_d[TOTAL-1] : sr_shift_d[0];
    div_tc_d     = (div_q == DCW'(CLK_DIV - 1));
    last_bit_d   = (bit_cnt_q == BCW'(LAST_BIT));
    last_word_d  = (word_cnt_q == WCW'(FRAME_WORDS - 1));
  end

`ifdef SERIAL_FRAME_PARITY_EN
  logic par_q;
  logic head_d;
  logic data_end_d;

  // After a parity bit, the first bit of the next word is already at the head
  always_comb begin
    head_d     = (MSB_FIRST != 0) ? sr_q[TOTAL-1] : sr_q[0];
    data_end_d = (bit_cnt_q == BCW'(WORD_WIDTH - 1));
  end
`endif

  // Frame FSM. The bit divider, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      gap_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_q       <= 1'b0;
      oclk_q     <= 1'b0;
      odat_q     <= 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // busy_q still high here means done was just pulsed; let it fall first
          if (send && !busy_q) begin
            state_q    <= SHIFT;
            sr_q       <= data;
            div_q      <= '0;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
            tx_q       <= 1'b1;
            oclk_q     <= 1'b0;
            odat_q     <= first_bit_d;
`ifdef SERIAL_FRAME_PARITY_EN
            par_q      <= first_bit_d;
`endif
          end else begin
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (!div_tc_d) begin
            div_q <= div_q + DCW'(1);
          end else begin
            div_q <= '0;
            if (!phase_q) begin
              phase_q <= 1'b1;
              oclk_q  <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              oclk_q  <= 1'b0;
              if (last_bit_d && last_word_d) begin
                tx_q   <= 1'b0;
                odat_q <= 1'b0;
                gap_q  <= '0;
                if (GAP_CYC > 0) begin
                  state_q <= GAP;
                end else begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                end
              end else begin
                if (last_bit_d) begin
                  bit_cnt_q  <= '0;
                  word_cnt_q <= word_cnt_q + WCW'(1);
                end else begin
                  bit_cnt_q <= bit_cnt_q + BCW'(1);
                end
`ifdef SERIAL_FRAME_PARITY_EN
                if (data_end_d) begin
                  sr_q   <= sr_shift_d;
                  odat_q <= par_q;
                end else if (last_bit_d) begin
                  odat_q <= head_d;
                  par_q  <= head_d;
                end else begin
                  sr_q   <= sr_shift_d;
                  odat_q <= shift_head_d;
                  par_q  <= par_q ^ shift_head_d;
                end
`else
                sr_q   <= sr_shift_d;
                odat_q <= shift_head_d;
`endif
              end
            end
          end
        end
        GAP: begin
          if (gap_q == GCW'(GAP_LAST)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            gap_q <= gap_q + GCW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b0;
          oclk_q  <= 1'b0;
          odat_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign transmission = tx_q;
  assign out_clock    = oclk_q;
  assign out_data     = odat_q;

endmodule
